decoded_word_serializer: RTL

//  Downstream stage of the 1-bit XOR decoder: accepts the WIDTH-bit decoded word

---
 rtl/decoded_word_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/decoded_word_serializer.sv
// decoded_word_serializer
//   Takes the WIDTH-bit word from the XOR decoder over a valid/ready handshake
//   and streams it out LANE bits per beat, least significant lane first, onto
//   the narrow bus that feeds the CGP loss bench.
//
//   Optional feature macro: PATTERN_CHECK_EN
//     defined   - every captured word is compared against the two legal decoder
//                 outputs (all zeros, or {WIDTH/2{2'b01}}); any other word sets
//                 the sticky pattern_err flag until reset. Data is passed unchanged.
//     undefined - no comparator is built and pattern_err is tied low.
//
//   WIDTH must be a multiple of LANE.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no word held; in_ready=1, out_valid=0
//   SHIFT | word held; beat k presented on out_data, advances on out_ready
module decoded_word_serializer #(
    parameter int WIDTH = 128,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANE-1:0]  out_data,
    output logic             out_last,
    output logic             pattern_err
);

    localparam int BEATS = WIDTH / LANE;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] word_sr;
    logic [WIDTH-1:0] sr_next;
    logic             capture;

    // The held word shifts down one lane per accepted beat, so the next beat
    // is always the low lane of the shifted value.
    assign sr_next = word_sr >> LANE;

    // in_ready opens on the final accepted beat so the next word lands with no bubble.
    assign in_ready = (state == IDLE) | ((state == SHIFT) & (k == K_LAST) & out_ready);
    assign capture  = in_valid & in_ready;

    // Serializer FSM: beat index, shift register and registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            word_sr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= SHIFT;
                        k         <= '0;
                        word_sr   <= in_word;
                        out_valid <= 1'b1;
                        out_data  <= in_word[LANE-1:0];
                        out_last  <= (K_LAST == '0);
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (k == K_LAST) begin
                            if (in_valid) begin
                                k         <= '0;
                                word_sr   <= in_word;
                                out_valid <= 1'b1;
                                out_data  <= in_word[LANE-1:0];
                                out_last  <= (K_LAST == '0);
                            end else begin
                                state     <= IDLE;
                                k         <= '0;
                                out_valid <= 1'b0;
                                out_data  <= '0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            k        <= k + KW'(1);
                            word_sr  <= sr_next;
                            out_data <= sr_next[LANE-1:0];
                            out_last <= ((k + KW'(1)) == K_LAST);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    k         <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PATTERN_CHECK_EN
    localparam logic [WIDTH-1:0] PAT_ONE = {(WIDTH/2){2'b01}};

    logic word_legal;

    assign word_legal = (in_word == '0) | (in_word == PAT_ONE);

    // Sticky flag: any captured word that is not a legal decoder output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_err <= 1'b0;
        end else if (capture && !word_legal) begin
            pattern_err <= 1'b1;
        end
    end
`else
    // No comparator in this build; capture is only needed by the checker.
    logic unused_capture;
    assign unused_capture = capture;
    assign pattern_err    = 1'b0;
`endif

endmodule
